// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the current access
//   STAT_W      : width of the optional grant statistics counters
//   dma_wins_tie: tie-break rule when both requesters ask in the same cycle
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_CPU,
    BUSY_DMA,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam int STAT_W = 16;

  // The CPU keeps priority unless the DMA has waited long enough and the
  // CPU is not holding a lock for an atomic sequence.
  function automatic logic dma_wins_tie(input logic starved, input logic locked);
    return starved && !locked;
  endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr: saturating starvation counter for the DMA requester.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   inc     : count one waiting cycle (saturates at MAX_WAIT)
//   clr     : clear the count (wins over inc)
//   starved : count has reached MAX_WAIT
module arb_wait_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign starved = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the core (cpu) and a
// DMA/debug master (dma). Fixed CPU priority, DMA starvation bound
// (MAX_WAIT cycles), and a CPU lock for atomic sequences.
//   clk, reset                 : clock (rising edge), async active-low reset
//   cpu_req/we/lock/addr/wdata : CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata         : one-cycle completion pulse and read data
//   dma_req/we/addr/wdata      : DMA request (level, held until dma_ack)
//   dma_ack, dma_rdata         : one-cycle completion pulse and read data
//   mem_req/we/addr/wdata      : memory request, held constant while busy
//   mem_rdata, mem_ready       : memory read data, access completion
//   gnt_cnt_cpu, gnt_cnt_dma   : grant counters, live only when the macro
//                                MEM_ARB_STATS_EN is defined, else tied 0
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_ack,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_wdata,
  output logic              dma_ack,
  output logic [DW-1:0]     dma_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic [STAT_W-1:0] gnt_cnt_cpu,
  output logic [STAT_W-1:0] gnt_cnt_dma
);

  arb_state_t state, state_nxt;
  owner_t     owner;
  logic       lock_q;
  logic       starved;
  logic       grant_cpu, grant_dma;
  logic       dma_owns;

  // Arbitration happens only in IDLE; in DONE the acked requester may
  // still be showing req, so it must not be granted again.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && dma_req) begin
        if (dma_wins_tie(starved, lock_q)) grant_dma = 1'b1;
        else                               grant_cpu = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  // DMA counts as owner from its grant through its ack cycle.
  assign dma_owns = (state == BUSY_DMA) || ((state == DONE) && (owner == OWN_DMA));

  arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc     (dma_req && !dma_owns),
    .clr     (!dma_req || grant_dma),
    .starved (starved)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_cpu)      state_nxt = BUSY_CPU;
        else if (grant_dma) state_nxt = BUSY_DMA;
      end
      BUSY_CPU: if (mem_ready) state_nxt = DONE;
      BUSY_DMA: if (mem_ready) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    mem_req = (state == BUSY_CPU) || (state == BUSY_DMA);
    cpu_ack = (state == DONE) && (owner == OWN_CPU);
    dma_ack = (state == DONE) && (owner == OWN_DMA);
  end

  // Winner's request is latched at grant and held for the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_CPU;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_cpu) begin
      owner     <= OWN_CPU;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else if (grant_dma) begin
      owner     <= OWN_DMA;
      mem_we    <= dma_we;
      mem_addr  <= dma_addr;
      mem_wdata <= dma_wdata;
    end
  end

  // Lock is set by a locked CPU grant and cleared by any grant made while
  // cpu_lock is low; a DMA grant with cpu_lock high leaves it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= 1'b0;
    end else if (grant_cpu && cpu_lock) begin
      lock_q <= 1'b1;
    end else if ((grant_cpu || grant_dma) && !cpu_lock) begin
      lock_q <= 1'b0;
    end
  end

  // Read data is captured on completion, reads and writes alike.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (mem_ready) begin
      if (state == BUSY_CPU) cpu_rdata <= mem_rdata;
      if (state == BUSY_DMA) dma_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_cpu, cnt_dma;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_cpu <= '0;
      cnt_dma <= '0;
    end else begin
      if (grant_cpu) cnt_cpu <= cnt_cpu + STAT_W'(1);
      if (grant_dma) cnt_dma <= cnt_dma + STAT_W'(1);
    end
  end

  assign gnt_cnt_cpu = cnt_cpu;
  assign gnt_cnt_dma = cnt_dma;
`else
  assign gnt_cnt_cpu = '0;
  assign gnt_cnt_dma = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter.
// A transaction-level reference model predicts each grant and each
// completion; a monitor compares the DUT against those predictions.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [15:0]   gnt_cnt_cpu, gnt_cnt_dma;

  mem_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_lock    (cpu_lock),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ack     (dma_ack),
    .dma_rdata   (dma_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .gnt_cnt_cpu (gnt_cnt_cpu),
    .gnt_cnt_dma (gnt_cnt_dma)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=missing expected=present at %0t", name, $time);
  endtask

  // ---------------- stimulus control ----------------
  int   cpu_en = 0, dma_en = 0;   // random requesters active
  int   cont = 0;                 // keep req high back-to-back
  int   lock_mode = 0;            // 0 random, 1 never, 2 always
  int   ovr = 0;                  // main process drives requests directly
  int   mem_fixed = -1;           // fixed memory latency, -1 random
  logic force_rd = 1'b0;
  logic [DW-1:0] rd_val = '0;
  int   cpu_age = 0, dma_age = 0;

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_addr  = $urandom;
    cpu_we    = 1'($urandom % 2);
    cpu_wdata = $urandom;
    cpu_lock  = (lock_mode == 0) ? 1'($urandom % 2) : (lock_mode == 2);
  endtask

  task automatic new_dma();
    dma_req   = 1'b1;
    dma_addr  = $urandom;
    dma_we    = 1'($urandom % 2);
    dma_wdata = $urandom;
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      cpu_req = 1'b0;
      cpu_age = 0;
    end else if (ovr == 0) begin
      if (cpu_req) begin
        cpu_age++;
        if (cpu_ack) begin
          cpu_age = 0;
          if (cpu_en != 0 && cont != 0) new_cpu();
          else cpu_req = 1'b0;
        end else if (cpu_age > 200) begin
          fail_now("cpu_ack_timeout");
          cpu_req = 1'b0;
          cpu_age = 0;
        end
      end else if (cpu_en != 0 && (cont != 0 || $urandom % 3 == 0)) begin
        new_cpu();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      dma_req = 1'b0;
      dma_age = 0;
    end else if (ovr == 0) begin
      if (dma_req) begin
        dma_age++;
        if (dma_ack) begin
          dma_age = 0;
          if (dma_en != 0 && cont != 0) new_dma();
          else dma_req = 1'b0;
        end else if (dma_age > 200) begin
          fail_now("dma_ack_timeout");
          dma_req = 1'b0;
          dma_age = 0;
        end
      end else if (dma_en != 0 && (cont != 0 || $urandom % 3 == 0)) begin
        new_dma();
      end
    end
  end

  // Memory: random or fixed latency; stray mem_ready pulses while idle.
  int mem_cnt = 0, mem_target = 0;
  bit mem_in_acc = 0;
  initial forever begin
    @(negedge clk);
    mem_rdata = $urandom;
    if (mem_req) begin
      if (!mem_in_acc) begin
        mem_in_acc = 1;
        mem_cnt    = 0;
        mem_target = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 4));
      end
      if (mem_cnt == mem_target) begin
        mem_ready = 1'b1;
        if (force_rd) mem_rdata = rd_val;
      end else begin
        mem_ready = 1'b0;
      end
      mem_cnt++;
    end else begin
      mem_in_acc = 0;
      mem_ready  = 1'($urandom % 4 == 0);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            who;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    int            who;
    logic [DW-1:0] rdata;
  } ack_t;

  gnt_t gq[$];
  ack_t aq[$];

  int m_phase = 0;   // 0 free, 1 access in flight, 2 ack cycle
  int m_who = 0;     // 0 cpu, 1 dma
  int m_wait = 0;    // cycles the DMA has waited unserved
  int m_lock = 0;
  int m_gc = 0, m_gd = 0;
  int win;
  bit dma_owner;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_phase = 0; m_who = 0; m_wait = 0; m_lock = 0; m_gc = 0; m_gd = 0;
      gq.delete();
      aq.delete();
    end else begin
      win = -1;
      dma_owner = (m_phase != 0) && (m_who == 1);
      if (m_phase == 0) begin
        if (cpu_req && dma_req) win = (m_wait >= MAX_WAIT && m_lock == 0) ? 1 : 0;
        else if (cpu_req)       win = 0;
        else if (dma_req)       win = 1;
      end
      if (win == 0) begin
        gq.push_back('{0, cpu_addr, cpu_we, cpu_wdata});
        m_gc++;
      end else if (win == 1) begin
        gq.push_back('{1, dma_addr, dma_we, dma_wdata});
        m_gd++;
      end
      if (win >= 0) begin
        if (cpu_lock) begin
          if (win == 0) m_lock = 1;
        end else begin
          m_lock = 0;
        end
        m_phase = 1;
        m_who   = win;
      end else if (m_phase == 1) begin
        if (mem_ready) begin
          aq.push_back('{m_who, mem_rdata});
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (!dma_req || win == 1) m_wait = 0;
      else if (!dma_owner && m_wait < MAX_WAIT) m_wait++;
    end
  end

  // ---------------- monitor ----------------
  logic prev_mreq = 1'b0;
  gnt_t cur;
  gnt_t g;
  ack_t a;

  initial forever begin
    @(negedge clk);
    chk("mem_req", mem_req, m_phase == 1);
    chk("cpu_ack", cpu_ack, m_phase == 2 && m_who == 0);
    chk("dma_ack", dma_ack, m_phase == 2 && m_who == 1);
    if (mem_req && !prev_mreq) begin
      if (gq.size() == 0) begin
        fail_now("grant_expected");
      end else begin
        g = gq.pop_front();
        chk("grant_addr", mem_addr, g.addr);
        chk("grant_we", mem_we, g.we);
        chk("grant_wdata", mem_wdata, g.wdata);
        cur = g;
      end
    end else if (mem_req && prev_mreq) begin
      chk("hold_addr", mem_addr, cur.addr);
      chk("hold_we", mem_we, cur.we);
      chk("hold_wdata", mem_wdata, cur.wdata);
    end
    if (cpu_ack || dma_ack) begin
      if (aq.size() == 0) begin
        fail_now("ack_expected");
      end else begin
        a = aq.pop_front();
        chk("ack_owner", dma_ack, a.who == 1);
        chk("ack_rdata", dma_ack ? dma_rdata : cpu_rdata, a.rdata);
      end
    end
    prev_mreq = mem_req;
  end

  // ---------------- directed helpers ----------------
  task automatic quiesce();
    bit ok;
    cpu_en = 0; dma_en = 0; cont = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!cpu_req && !dma_req && m_phase == 0) begin
        ok = 1;
        break;
      end
    end
    chk("quiesce", ok, 1);
  endtask

  task automatic run_one(input int who, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output int ack_at, output int busy,
                         output int acks);
    ack_at = -1; busy = 0; acks = 0;
    @(negedge clk);
    if (who == 0) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_lock = 1'b0;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) busy++;
      if (cpu_ack || dma_ack) begin
        acks++;
        if (ack_at < 0) ack_at = i + 1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int ack_at, busy, acks;
  bit saw_req;
  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_gnt_cpu", gnt_cnt_cpu, 0);
    reset = 1'b1;

    // CPU read alone, minimum latency, known data
    ovr = 1; mem_fixed = 0; force_rd = 1'b1; rd_val = 32'hDEADBEEF;
    run_one(0, 1'b0, 32'h100, 32'h0, ack_at, busy, acks);
    force_rd = 1'b0;
    chk("cpu_read_latency", ack_at, 2);
    chk("cpu_read_busy", busy, 1);
    chk("cpu_read_acks", acks, 1);
    chk("cpu_read_rdata", cpu_rdata, 32'hDEADBEEF);

    // DMA write with delayed memory
    mem_fixed = 5;
    run_one(1, 1'b1, 32'h2000, 32'h55AA, ack_at, busy, acks);
    chk("dma_write_busy", busy, 6);
    chk("dma_write_acks", acks, 1);
    ovr = 0; mem_fixed = -1;

    // random traffic
    lock_mode = 0; cpu_en = 1; dma_en = 1;
    repeat (300) @(negedge clk);
    quiesce();

    // both continuously, no lock, 1-cycle memory: starvation bound
    mem_fixed = 0; lock_mode = 1; cont = 1; cpu_en = 1; dma_en = 1;
    repeat (120) @(negedge clk);
    quiesce();

    // both continuously with lock: DMA held off until CPU stops
    lock_mode = 2; cont = 1; cpu_en = 1; dma_en = 1;
    repeat (120) @(negedge clk);
    cpu_en = 0;
    repeat (40) @(negedge clk);
    quiesce();

    // reset in the middle of a DMA access
    ovr = 1; mem_fixed = 1000; saw_req = 0;
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h3000; dma_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) saw_req = 1;
    end
    chk("rst_test_busy", saw_req, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_dma_ack", dma_ack, 0);
    chk("async_rst_dma_rdata", dma_rdata, 0);
    chk("async_rst_gnt_dma", gnt_cnt_dma, 0);
    @(negedge clk);
    dma_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_fixed = -1;
    repeat (6) @(negedge clk);
    run_one(1, 1'b0, 32'h44, 32'h0, ack_at, busy, acks);
    chk("post_rst_dma_acks", acks, 1);
    ovr = 0;

    // more random traffic
    lock_mode = 0; cpu_en = 1; dma_en = 1;
    repeat (200) @(negedge clk);
    quiesce();
    repeat (3) @(negedge clk);
    chk("grant_q_drained", gq.size(), 0);
    chk("ack_q_drained", aq.size(), 0);
`ifdef MEM_ARB_STATS_EN
    chk("stat_cpu", gnt_cnt_cpu, m_gc[15:0]);
    chk("stat_dma", gnt_cnt_dma, m_gd[15:0]);
`else
    chk("stat_cpu_off", gnt_cnt_cpu, 0);
    chk("stat_dma_off", gnt_cnt_dma, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
